bht_update_queue: RTL

- Write side of the two-bit branch history table (BHT): collects resolved conditional branches from the Memory stage and issues the BHT writes.
- Computes each saturating-counter update and buffers updates in a small coalescing queue.
- Drains the queue into the BHT write port whenever that port is free.
- Forwards pending (not yet written) counter states to the Fetch-stage lookup, so fetch never sees a stale entry.

---
 rtl/bht_update_queue_pkg.sv | 18 +
 rtl/bht_update_queue_if.sv | 34 +++
 rtl/bht_update_queue_satCounter2.sv | 19 +
 rtl/bht_update_queue.sv | 126 ++++++++++++
 4 files changed

// File: rtl/bht_update_queue_pkg.sv
// Shared types and constants for the BHT write-side update queue.
// The entry struct is sized by BHT_K, so instances must keep their k equal to it.
package bht_update_queue_pkg;

    localparam int BHT_K = 10;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [BHT_K-1:0] idx;
        logic [1:0]       dir;
    } bht_entry_t;

endpackage

// File: rtl/bht_update_queue_if.sv
// Pipeline-facing bundle of the BHT update queue: M-stage branch inputs,
// the BHT write port, and the fetch-stage forwarding path.
interface bht_update_queue_if #(
    parameter int XLEN  = 64,
    parameter int k     = 10,
    parameter int DEPTH = 4
);
    logic                     StallM;
    logic                     FlushM;
    logic                     BranchM;
    logic [XLEN-1:0]          PCM;
    logic                     PCSrcM;
    logic [1:0]               BPDirM;
    logic                     WrBusy;
    logic [XLEN-1:0]          PCNextF;
    logic                     BHTWrEn;
    logic [k-1:0]             BHTWrIdx;
    logic [1:0]               BHTWrData;
    logic                     FwdHitF;
    logic [1:0]               FwdDirF;
    logic                     StallReqM;
    logic [$clog2(DEPTH):0]   Count;

    modport master (
        output StallM, FlushM, BranchM, PCM, PCSrcM, BPDirM, WrBusy, PCNextF,
        input  BHTWrEn, BHTWrIdx, BHTWrData, FwdHitF, FwdDirF, StallReqM, Count
    );

    modport slave (
        input  StallM, FlushM, BranchM, PCM, PCSrcM, BPDirM, WrBusy, PCNextF,
        output BHTWrEn, BHTWrIdx, BHTWrData, FwdHitF, FwdDirF, StallReqM, Count
    );

endinterface

// File: rtl/bht_update_queue_satCounter2.sv
// Two-bit saturating branch counter: one step toward taken or not-taken.
module satCounter2
    import bht_update_queue_pkg::*;
(
    input  logic [1:0] dir_i,
    input  logic       taken_i,
    output logic [1:0] dir_o
);

    always_comb begin
        dir_o = dir_i;
        if (taken_i) begin
            if (dir_i != STRONG_T) dir_o = dir_i + 2'd1;
        end else begin
            if (dir_i != STRONG_NT) dir_o = dir_i - 2'd1;
        end
    end

endmodule

// File: rtl/bht_update_queue.sv
// Coalescing queue of pending BHT counter updates; drains into the BHT write
// port when it is free and forwards pending counters to the fetch lookup.
module bht_update_queue
    import bht_update_queue_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int k     = BHT_K,
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              reset,
    bht_update_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    function automatic logic [k-1:0] bhtHash(input logic [XLEN-1:0] pc);
        return {pc[k+1] ^ pc[1], pc[k:2]};
    endfunction

    bht_entry_t      entries_q [DEPTH];
    bht_entry_t      entries_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [k-1:0]    idxM, idxF;
    logic            drain, hit, headMatch, update, enq, stallReq;
    logic [PW-1:0]   hitPos;
    logic [1:0]      srcDir, newDir;
    logic            fwdHit;
    logic [1:0]      fwdDir;

    assign idxM  = bhtHash(bus.PCM);
    assign idxF  = bhtHash(bus.PCNextF);
    assign drain = (count_q != '0) && !bus.WrBusy;

    // The head entry leaving this cycle cannot absorb a new update; it only
    // supplies the source state and the update enqueues behind it.
    always_comb begin
        hit    = 1'b0;
        hitPos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid && entries_q[i].idx == idxM &&
                !(drain && PW'(i) == head_q)) begin
                hit    = 1'b1;
                hitPos = PW'(i);
            end
        end
    end

    assign headMatch = drain && entries_q[head_q].valid && entries_q[head_q].idx == idxM;

    always_comb begin
        srcDir = bus.BPDirM;
        if (hit)            srcDir = entries_q[hitPos].dir;
        else if (headMatch) srcDir = entries_q[head_q].dir;
    end

    satCounter2 u_satCounter2 (
        .dir_i   (srcDir),
        .taken_i (bus.PCSrcM),
        .dir_o   (newDir)
    );

    assign stallReq = bus.BranchM && (count_q == CW'(DEPTH)) && !hit && !drain;
    assign update   = bus.BranchM && !bus.StallM && !bus.FlushM && !stallReq;
    assign enq      = update && !hit;

    always_comb begin
        fwdHit = 1'b0;
        fwdDir = STRONG_NT;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid && entries_q[i].idx == idxF) begin
                fwdHit = 1'b1;
                fwdDir = entries_q[i].dir;
            end
        end
    end

    // Invalidate the draining head before the enqueue so a full queue that
    // drains and enqueues together reuses the same slot correctly.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q + CW'(enq) - CW'(drain);
        if (drain) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + 1'b1;
        end
        if (update && hit) begin
            entries_d[hitPos].dir = newDir;
        end
        if (enq) begin
            entries_d[tail_q].valid = 1'b1;
            entries_d[tail_q].idx   = idxM;
            entries_d[tail_q].dir   = newDir;
            tail_d                  = tail_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    assign bus.BHTWrEn   = drain;
    assign bus.BHTWrIdx  = entries_q[head_q].idx;
    assign bus.BHTWrData = entries_q[head_q].dir;
    assign bus.FwdHitF   = fwdHit;
    assign bus.FwdDirF   = fwdDir;
    assign bus.StallReqM = stallReq;
    assign bus.Count     = count_q;

endmodule
